// File: rtl/rf_xfer_sequencer_pkg.sv
// Shared constants and types for the RegisterFile transfer sequencer.
// RF_SWAP_EN adds the three SWAP states to the state encoding.
package rf_pkg;

    localparam logic [2:0] FUNSEL_DEC  = 3'b000;
    localparam logic [2:0] FUNSEL_INC  = 3'b001;
    localparam logic [2:0] FUNSEL_LOAD = 3'b010;
    localparam logic [2:0] FUNSEL_CLR  = 3'b011;

    typedef enum logic [2:0] {
        OP_MOV  = 3'd0,
        OP_LDI  = 3'd1,
        OP_CLR  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SWAP = 3'd5
    } op_e;

    localparam logic [2:0] REG_R1 = 3'd0;
    localparam logic [2:0] REG_R2 = 3'd1;
    localparam logic [2:0] REG_R3 = 3'd2;
    localparam logic [2:0] REG_R4 = 3'd3;
    localparam logic [2:0] REG_S1 = 3'd4;
    localparam logic [2:0] REG_S2 = 3'd5;
    localparam logic [2:0] REG_S3 = 3'd6;
    localparam logic [2:0] REG_S4 = 3'd7;

`ifdef RF_SWAP_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1
    } state_e;
`endif

    // S4 is the SWAP scratch slot, so it may not be an operand
    function automatic logic swap_ok(logic [2:0] s, logic [2:0] d);
        return (s != REG_S4) && (d != REG_S4);
    endfunction

endpackage

// File: rtl/rf_xfer_sequencer_if.sv
// Command handshake plus RegisterFile control bundle.
// master = command source / RegisterFile side, slave = sequencer.
interface rf_xfer_if #(
    parameter int DATA_W = 16
);
    logic              CmdValid;
    logic              CmdReady;
    logic [2:0]        CmdOp;
    logic [2:0]        CmdSrc;
    logic [2:0]        CmdDst;
    logic [DATA_W-1:0] CmdData;
    logic              Done;
    logic              Err;
    logic [2:0]        FunSel;
    logic [3:0]        RegSel;
    logic [3:0]        ScrSel;
    logic [2:0]        OutASel;
    logic [2:0]        OutBSel;
    logic              ISel;
    logic [DATA_W-1:0] IData;

    modport master (
        output CmdValid, CmdOp, CmdSrc, CmdDst, CmdData,
        input  CmdReady, Done, Err, FunSel, RegSel, ScrSel,
        input  OutASel, OutBSel, ISel, IData
    );

    modport slave (
        input  CmdValid, CmdOp, CmdSrc, CmdDst, CmdData,
        output CmdReady, Done, Err, FunSel, RegSel, ScrSel,
        output OutASel, OutBSel, ISel, IData
    );
endinterface

// File: rtl/rf_xfer_sequencer_enable_decode.sv
// Register code + strobe to active-low RegSel/ScrSel enables.
module rf_enable_decode (
    input  logic [2:0] code_i,
    input  logic       en_i,
    output logic [3:0] reg_sel_o,
    output logic [3:0] scr_sel_o
);
    // bit3 is the lowest code of each bank, hence the inverted index
    always_comb begin
        reg_sel_o = 4'b1111;
        scr_sel_o = 4'b1111;
        if (en_i) begin
            if (!code_i[2]) reg_sel_o[~code_i[1:0]] = 1'b0;
            else            scr_sel_o[~code_i[1:0]] = 1'b0;
        end
    end
endmodule

// File: rtl/rf_xfer_sequencer.sv
// Command-driven RegisterFile write/control sequencer.
// Define RF_SWAP_EN to build the 3-step SWAP through S4.
module rf_xfer_sequencer
    import rf_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input logic      Clock,
    input logic      Reset,
    rf_xfer_if.slave bus
);
    state_e            state_q;
    logic [2:0]        fun_q;
    logic [2:0]        outa_q;
    logic [2:0]        outb_q;
    logic              isel_q;
    logic [DATA_W-1:0] idata_q;
    logic [2:0]        tgt_q;
    logic              wen_q;
    logic              done_q;
    logic              err_q;
`ifdef RF_SWAP_EN
    logic [2:0]        src_q;
    logic [2:0]        dst_q;
`endif
    logic [3:0]        reg_sel_w;
    logic [3:0]        scr_sel_w;

    // every cycle falls back to IDLE outputs unless a state overrides
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            fun_q   <= FUNSEL_LOAD;
            outa_q  <= REG_R1;
            outb_q  <= REG_R1;
            isel_q  <= 1'b0;
            idata_q <= '0;
            tgt_q   <= REG_R1;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RF_SWAP_EN
            src_q   <= REG_R1;
            dst_q   <= REG_R1;
`endif
        end else begin
            fun_q   <= FUNSEL_LOAD;
            outa_q  <= REG_R1;
            outb_q  <= REG_R1;
            isel_q  <= 1'b0;
            idata_q <= '0;
            tgt_q   <= REG_R1;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (bus.CmdValid) begin
                    state_q <= ST_EXEC;
                    outb_q  <= bus.CmdDst;
                    tgt_q   <= bus.CmdDst;
                    wen_q   <= 1'b1;
                    case (op_e'(bus.CmdOp))
                        OP_MOV: begin
                            outa_q <= bus.CmdSrc;
                            isel_q <= 1'b1;
                        end
                        OP_LDI: idata_q <= bus.CmdData;
                        OP_CLR: fun_q <= FUNSEL_CLR;
                        OP_INC: fun_q <= FUNSEL_INC;
                        OP_DEC: fun_q <= FUNSEL_DEC;
`ifdef RF_SWAP_EN
                        OP_SWAP: begin
                            if (swap_ok(bus.CmdSrc, bus.CmdDst)) begin
                                state_q <= ST_SW1;
                                src_q   <= bus.CmdSrc;
                                dst_q   <= bus.CmdDst;
                                tgt_q   <= REG_S4;
                                outa_q  <= bus.CmdSrc;
                                isel_q  <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                outb_q  <= REG_R1;
                                wen_q   <= 1'b0;
                                err_q   <= 1'b1;
                            end
                        end
`endif
                        default: begin
                            state_q <= ST_IDLE;
                            outb_q  <= REG_R1;
                            wen_q   <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
`ifdef RF_SWAP_EN
                ST_SW1: begin
                    state_q <= ST_SW2;
                    tgt_q   <= src_q;
                    wen_q   <= 1'b1;
                    outa_q  <= dst_q;
                    outb_q  <= dst_q;
                    isel_q  <= 1'b1;
                end
                ST_SW2: begin
                    state_q <= ST_SW3;
                    tgt_q   <= dst_q;
                    wen_q   <= 1'b1;
                    outa_q  <= REG_S4;
                    outb_q  <= dst_q;
                    isel_q  <= 1'b1;
                end
                ST_SW3: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    rf_enable_decode u_dec (
        .code_i    (tgt_q),
        .en_i      (wen_q),
        .reg_sel_o (reg_sel_w),
        .scr_sel_o (scr_sel_w)
    );

    assign bus.CmdReady = (state_q == ST_IDLE);
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
    assign bus.FunSel   = fun_q;
    assign bus.RegSel   = reg_sel_w;
    assign bus.ScrSel   = scr_sel_w;
    assign bus.OutASel  = outa_q;
    assign bus.OutBSel  = outb_q;
    assign bus.ISel     = isel_q;
    assign bus.IData    = idata_q;

endmodule

// File: tb/tb_rf_xfer_sequencer.sv
// Directed bench for rf_xfer_sequencer with a RegisterFile model.
// SWAP expectations follow RF_SWAP_EN.
module tb_rf_xfer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rf_xfer_if #(.DATA_W(16)) bus ();

    rf_xfer_sequencer #(.DATA_W(16)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // RegisterFile model: codes 0-3 = R1-R4, 4-7 = S1-S4
    bit   [15:0] rf [8];
    logic [15:0] iv;
    logic        en;

    always @(posedge clk) begin
        iv = bus.ISel ? rf[bus.OutASel] : bus.IData;
        for (int c = 0; c < 8; c++) begin
            en = (c < 4) ? !bus.RegSel[3-c] : !bus.ScrSel[7-c];
            if (en) begin
                case (bus.FunSel)
                    3'b000:  rf[c] <= rf[c] - 16'd1;
                    3'b001:  rf[c] <= rf[c] + 16'd1;
                    3'b010:  rf[c] <= iv;
                    3'b011:  rf[c] <= 16'd0;
                    default: rf[c] <= rf[c];
                endcase
            end
        end
    end

    // presents a command for one accept edge; returns in the cycle after
    task automatic drive(input logic [2:0] op, input logic [2:0] s,
                         input logic [2:0] d, input logic [15:0] data);
        bus.CmdOp    = op;
        bus.CmdSrc   = s;
        bus.CmdDst   = d;
        bus.CmdData  = data;
        bus.CmdValid = 1'b1;
        @(negedge clk);
        bus.CmdValid = 1'b0;
        bus.CmdData  = 16'h0;
    endtask

    task automatic preload(input logic [2:0] d, input logic [15:0] data);
        @(negedge clk);
        drive(3'b001, 3'd0, d, data);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.RegSel, bus.ScrSel} !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_en: got %b want %b",
                     {bus.RegSel, bus.ScrSel}, 8'hFF);
        end
        n_chk++;
        if ({bus.CmdReady, bus.Done, bus.Err, bus.FunSel, bus.ISel}
            !== 7'b1000100) begin
            n_fail++;
            $display("FAIL rst_ctl: got %b want %b",
                     {bus.CmdReady, bus.Done, bus.Err, bus.FunSel, bus.ISel},
                     7'b1000100);
        end
        n_chk++;
        if ({bus.OutASel, bus.OutBSel, bus.IData} !== 22'h0) begin
            n_fail++;
            $display("FAIL rst_sel: got %h want 0",
                     {bus.OutASel, bus.OutBSel, bus.IData});
        end
        // abort an LDI to R1 in the middle of its EXEC cycle
        drive(3'b001, 3'd0, 3'd0, 16'hAAAA);
        n_chk++;
        if (bus.RegSel !== 4'b0111) begin
            n_fail++;
            $display("FAIL rst_pre: got %b want %b", bus.RegSel, 4'b0111);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.RegSel, bus.ScrSel, bus.Done} !== 9'h1FE) begin
            n_fail++;
            $display("FAIL rst_async: got %b want %b",
                     {bus.RegSel, bus.ScrSel, bus.Done}, 9'h1FE);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.CmdReady, bus.Done} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_after: got %b want %b",
                     {bus.CmdReady, bus.Done}, 2'b10);
        end
        n_chk++;
        if (rf[0] !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_abort: got %h want %h", rf[0], 16'h0);
        end
    endtask

    task automatic test_ldi;
        @(negedge clk);
        drive(3'b001, 3'd0, 3'd2, 16'hBEEF);
        n_chk++;
        if ({bus.RegSel, bus.ScrSel} !== 8'b1101_1111) begin
            n_fail++;
            $display("FAIL ldi_en: got %b want %b",
                     {bus.RegSel, bus.ScrSel}, 8'b1101_1111);
        end
        n_chk++;
        if ({bus.ISel, bus.FunSel, bus.IData} !== {1'b0, 3'b010, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL ldi_ctl: got %h want %h",
                     {bus.ISel, bus.FunSel, bus.IData},
                     {1'b0, 3'b010, 16'hBEEF});
        end
        n_chk++;
        if ({bus.OutBSel, bus.CmdReady, bus.Done} !== 5'b010_00) begin
            n_fail++;
            $display("FAIL ldi_exec: got %b want %b",
                     {bus.OutBSel, bus.CmdReady, bus.Done}, 5'b010_00);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Done, bus.CmdReady, bus.RegSel} !== 6'b11_1111) begin
            n_fail++;
            $display("FAIL ldi_done: got %b want %b",
                     {bus.Done, bus.CmdReady, bus.RegSel}, 6'b11_1111);
        end
        n_chk++;
        if (rf[2] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ldi_r3: got %h want %h", rf[2], 16'hBEEF);
        end
        @(negedge clk);
        n_chk++;
        if (bus.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL ldi_pulse: got %b want %b", bus.Done, 1'b0);
        end
    endtask

    task automatic test_mov;
        preload(3'd0, 16'h1234);
        @(negedge clk);
        drive(3'b000, 3'd0, 3'd5, 16'h0);
        n_chk++;
        if ({bus.RegSel, bus.ScrSel} !== 8'b1111_1011) begin
            n_fail++;
            $display("FAIL mov_en: got %b want %b",
                     {bus.RegSel, bus.ScrSel}, 8'b1111_1011);
        end
        n_chk++;
        if ({bus.OutASel, bus.ISel, bus.FunSel} !== 7'b000_1_010) begin
            n_fail++;
            $display("FAIL mov_ctl: got %b want %b",
                     {bus.OutASel, bus.ISel, bus.FunSel}, 7'b000_1_010);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Done, rf[5]} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL mov_s2: got %h want %h",
                     {bus.Done, rf[5]}, {1'b1, 16'h1234});
        end
    endtask

    task automatic test_back_to_back;
        preload(3'd3, 16'hFFFF);
        @(negedge clk);
        drive(3'b011, 3'd0, 3'd3, 16'h0);
        n_chk++;
        if ({bus.FunSel, bus.RegSel} !== 7'b001_1110) begin
            n_fail++;
            $display("FAIL inc_ctl: got %b want %b",
                     {bus.FunSel, bus.RegSel}, 7'b001_1110);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Done, bus.CmdReady, rf[3]} !== {2'b11, 16'h0000}) begin
            n_fail++;
            $display("FAIL inc_wrap: got %h want %h",
                     {bus.Done, bus.CmdReady, rf[3]}, {2'b11, 16'h0000});
        end
        drive(3'b100, 3'd0, 3'd3, 16'h0);
        n_chk++;
        if ({bus.FunSel, bus.RegSel, bus.Done} !== 8'b000_1110_0) begin
            n_fail++;
            $display("FAIL dec_ctl: got %b want %b",
                     {bus.FunSel, bus.RegSel, bus.Done}, 8'b000_1110_0);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Done, rf[3]} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL dec_r4: got %h want %h",
                     {bus.Done, rf[3]}, {1'b1, 16'hFFFF});
        end
    endtask

    task automatic test_swap;
        preload(3'd0, 16'h0011);
        preload(3'd1, 16'h0022);
        @(negedge clk);
        drive(3'b101, 3'd0, 3'd1, 16'h0);
`ifdef RF_SWAP_EN
        n_chk++;
        if ({bus.RegSel, bus.ScrSel, bus.OutASel, bus.ISel, bus.FunSel}
            !== 15'b1111_1110_000_1_010) begin
            n_fail++;
            $display("FAIL sw1: got %b want %b",
                     {bus.RegSel, bus.ScrSel, bus.OutASel, bus.ISel, bus.FunSel},
                     15'b1111_1110_000_1_010);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.RegSel, bus.ScrSel, bus.OutASel, bus.OutBSel}
            !== 14'b0111_1111_001_001) begin
            n_fail++;
            $display("FAIL sw2: got %b want %b",
                     {bus.RegSel, bus.ScrSel, bus.OutASel, bus.OutBSel},
                     14'b0111_1111_001_001);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.RegSel, bus.ScrSel, bus.OutASel, bus.Done}
            !== 12'b1011_1111_111_0) begin
            n_fail++;
            $display("FAIL sw3: got %b want %b",
                     {bus.RegSel, bus.ScrSel, bus.OutASel, bus.Done},
                     12'b1011_1111_111_0);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Done, rf[0], rf[1]} !== {1'b1, 16'h0022, 16'h0011}) begin
            n_fail++;
            $display("FAIL sw_done: got %h want %h",
                     {bus.Done, rf[0], rf[1]}, {1'b1, 16'h0022, 16'h0011});
        end
`else
        n_chk++;
        if ({bus.Err, bus.RegSel, bus.ScrSel, bus.CmdReady, bus.Done}
            !== 11'b1_1111_1111_1_0) begin
            n_fail++;
            $display("FAIL swap_off: got %b want %b",
                     {bus.Err, bus.RegSel, bus.ScrSel, bus.CmdReady, bus.Done},
                     11'b1_1111_1111_1_0);
        end
        @(negedge clk);
        n_chk++;
        if ({bus.Err, bus.Done, rf[0], rf[1], rf[7]}
            !== {2'b00, 16'h0011, 16'h0022, 16'h0000}) begin
            n_fail++;
            $display("FAIL swap_off_rf: got %h want %h",
                     {bus.Err, bus.Done, rf[0], rf[1], rf[7]},
                     {2'b00, 16'h0011, 16'h0022, 16'h0000});
        end
`endif
    endtask

    task automatic test_illegal;
        logic [2:0] ops [2];
        logic [2:0] dsts [2];
        ops[0] = 3'b110; dsts[0] = 3'd1;
        ops[1] = 3'b101; dsts[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(ops[k], 3'd0, dsts[k], 16'h5A5A);
            n_chk++;
            if ({bus.Err, bus.RegSel, bus.ScrSel, bus.CmdReady, bus.Done}
                !== 11'b1_1111_1111_1_0) begin
                n_fail++;
                $display("FAIL illegal%0d: got %b want %b", k,
                         {bus.Err, bus.RegSel, bus.ScrSel, bus.CmdReady, bus.Done},
                         11'b1_1111_1111_1_0);
            end
            @(negedge clk);
            n_chk++;
            if ({bus.Err, bus.Done} !== 2'b00) begin
                n_fail++;
                $display("FAIL illegal%0d_end: got %b want %b", k,
                         {bus.Err, bus.Done}, 2'b00);
            end
        end
    endtask

    initial begin
        bus.CmdValid = 1'b0;
        bus.CmdOp    = 3'b000;
        bus.CmdSrc   = 3'd0;
        bus.CmdDst   = 3'd0;
        bus.CmdData  = 16'h0;
        test_reset();
        test_ldi();
        test_mov();
        test_back_to_back();
        test_swap();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_xfer_sequencer.md
Name: rf_xfer_sequencer

Overview:
- Command-driven control sequencer that sits on the write/control side of the 8-entry RegisterFile (R1–R4, S1–S4).
- Accepts one register-transfer command at a time over a valid/ready handshake.
- Produces the FunSel/RegSel/ScrSel/OutASel/OutBSel sequence that executes the command, plus the data (IData/ISel) steering for the RegisterFile I input.
- Single- and multi-cycle ops; Done pulse on completion.

Parameters:
- DATA_W, 16, width of IData and CmdData (matches RegisterFile I width).

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command present.
- CmdReady  out  1  sequencer can accept a command.
- CmdOp  in  3  000 MOV, 001 LDI, 010 CLR, 011 INC, 100 DEC, 101 SWAP, 110/111 illegal.
- CmdSrc  in  3  source register code (0–3 = R1–R4, 4–7 = S1–S4).
- CmdDst  in  3  destination register code, same encoding.
- CmdData  in  DATA_W  immediate for LDI.
- Done  out  1  one-cycle pulse: command completed.
- Err  out  1  one-cycle pulse: command rejected.
- FunSel  out  3  RegisterFile function select.
- RegSel  out  4  active-low enables; bit3 = R1 … bit0 = R4.
- ScrSel  out  4  active-low enables; bit3 = S1 … bit0 = S4.
- OutASel  out  3  RegisterFile port-A read select.
- OutBSel  out  3  RegisterFile port-B read select.
- ISel  out  1  I-input mux: 1 = RegisterFile OutA loopback, 0 = IData.
- IData  out  DATA_W  immediate driven toward the I mux.

Behaviour:
- FunSel codes (package constants): DEC 000, INC 001, LOAD 010, CLR 011.
- Handshake:
  - CmdReady = 1 only in IDLE.
  - A command is accepted on the rising edge where CmdValid & CmdReady are both high.
  - Op, src, dst and data are latched at acceptance; inputs are ignored at all other times.
- States: IDLE, EXEC, SW1, SW2, SW3.
- IDLE outputs:
  - RegSel = ScrSel = 4'b1111, i.e. no register enabled.
  - FunSel = LOAD, OutASel = OutBSel = 0, ISel = 0, IData = 0.
- Enable decode: code c < 4 drives RegSel[3-c] = 0; c ≥ 4 drives ScrSel[7-c] = 0. Only the one enable is low; all others stay 1.
- Single-cycle ops (IDLE → EXEC → IDLE). Controls are asserted for exactly one EXEC cycle; the register updates at the end of EXEC.
  - MOV: OutASel = src, ISel = 1, FunSel = LOAD, enable dst.
  - LDI: ISel = 0, IData = latched CmdData, FunSel = LOAD, enable dst.
  - CLR / INC / DEC: FunSel = CLR / INC / DEC, enable dst.
- OutBSel = dst during EXEC and all SWAP states, for observation.
- SWAP: IDLE → SW1 → SW2 → SW3 → IDLE, ISel = 1 and FunSel = LOAD in each state.
  - SW1: S4 ← src (OutASel = src).
  - SW2: src ← dst (OutASel = dst).
  - SW3: dst ← S4 (OutASel = 7).
  - src == dst still executes and leaves the value unchanged.
  - src or dst == 7 (S4) is illegal.
- Done:
  - Asserts in the first IDLE cycle after the last control cycle, for one cycle.
  - A new command may be accepted in that same cycle.
  - Latency: 2 cycles accept→Done for single-cycle ops, 4 cycles for SWAP.
- Illegal op or illegal SWAP operands: stay in IDLE, no enable asserted, Err pulses the cycle after acceptance, Done stays 0.
- Reset:
  - Asynchronously forces IDLE with all IDLE outputs; Done = Err = 0.
  - A command in flight is aborted mid-operation with no further enables and no Done.
  - Partial SWAP results are left in place.

Optional Feature:
- Macro RF_SWAP_EN.
- Defined: SWAP (op 101) is supported as above, using S4 as the temporary.
- Undefined: op 101 is illegal (Err pulse); SW1–SW3 are not built; S4 is never written by the sequencer.

Decomposition:
- Package rf_pkg holds:
  - FunSel constants (FUNSEL_DEC/INC/LOAD/CLR).
  - Op enum (OP_MOV … OP_SWAP).
  - Register-code constants (REG_R1 = 0 … REG_S4 = 7).
  - State enum.
- Sub-module rf_enable_decode: 3-bit code + enable strobe → active-low RegSel/ScrSel pair. It is instantiated once and fed the per-state target code.

Test Plan:
- Reset asserted mid-EXEC → all enables 1111/1111 immediately; no Done; CmdReady = 1 after release.
- LDI dst = 2 (R3), data = 0xBEEF → one EXEC cycle with RegSel = 1101, ISel = 0, IData = 0xBEEF, FunSel = 010; Done 2 cycles after accept; a RegisterFile model reads R3 = 0xBEEF.
- MOV src = 0, dst = 5 after R1 = 0x1234 → OutASel = 0, ScrSel = 1011, ISel = 1; S2 = 0x1234.
- INC dst = 3 with R4 = 0xFFFF → FunSel = 001, RegSel = 1110; R4 = 0x0000 (wrap). Back-to-back DEC accepted in the Done cycle → R4 = 0xFFFF.
- SWAP R1 = 0x0011, R2 = 0x0022 → SW1 ScrSel = 1110, SW2 RegSel = 0111, SW3 RegSel = 1011 with OutASel = 7; R1 = 0x0022, R2 = 0x0011; Done 4 cycles after accept. Without RF_SWAP_EN → Err pulse, no enables.
- Op 110, and SWAP with dst = 7 → Err one cycle after accept, no enable asserted, CmdReady stays 1.
